// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: byte-strobed RW registers, optional
// read-only status registers, SLVERR for out-of-range / illegal writes.
module axi_lite_regfile #(
  parameter int                         AXI_DATA_WIDTH = 32,
  parameter int                         AXI_ADDR_WIDTH = 8,
  parameter int                         NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK        = '0,
  parameter logic [AXI_DATA_WIDTH-1:0]  RESET_VAL      = '0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [AXI_ADDR_WIDTH-1:0]               AWADDR,
  input  logic [2:0]                              AWPROT,
  input  logic                                    AWVALID,
  output logic                                    AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]               WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]             WSTRB,
  input  logic                                    WVALID,
  output logic                                    WREADY,
  output logic [1:0]                              BRESP,
  output logic                                    BVALID,
  input  logic                                    BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]               ARADDR,
  input  logic [2:0]                              ARPROT,
  input  logic                                    ARVALID,
  output logic                                    ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]               RDATA,
  output logic [1:0]                              RRESP,
  output logic                                    RVALID,
  input  logic                                    RREADY,
  output logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                     wr_pulse_o,
  input  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] status_i
);
  localparam int NB    = AXI_DATA_WIDTH / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = AXI_ADDR_WIDTH - OFF;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs;
  logic                      aw_held, w_held;
  logic [IDX_W-1:0]          aw_idx;
  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]             w_strb;
  logic                      aw_hs, w_hs, ar_hs, commit;
  logic                      wr_ok, rd_ok;
  logic [NUM_REGS-1:0]       wr_sel;
  logic [IDX_W-1:0]          ar_idx;
  logic [AXI_DATA_WIDTH-1:0] rd_val;

  // Protection bits and byte-offset bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{AWPROT, ARPROT, AWADDR[OFF-1:0], ARADDR[OFF-1:0]};

  // Readies are low during reset and come up in the first cycle after it.
  assign AWREADY = !reset && !aw_held && !BVALID;
  assign WREADY  = !reset && !w_held  && !BVALID;
  assign ARREADY = !reset && !RVALID;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID  && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = aw_held && w_held;
  assign ar_idx = ARADDR[AXI_ADDR_WIDTH-1:OFF];
  assign regs_o = regs;

  // Write target decode: only in-range, non-RO registers are writable.
  always_comb begin
    wr_ok  = 1'b0;
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(aw_idx) == 32'(i) && !RO_MASK[i]) begin
        wr_ok     = 1'b1;
        wr_sel[i] = 1'b1;
      end
    end
  end

  // Read mux: RO registers return the live status slice.
  always_comb begin
    rd_ok  = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(ar_idx) == 32'(i)) begin
        rd_ok  = 1'b1;
        rd_val = RO_MASK[i] ? status_i[i] : regs[i];
      end
    end
  end

  // Write channel capture, commit and B response.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_idx     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      BVALID     <= 1'b0;
      BRESP      <= OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= AWADDR[AXI_ADDR_WIDTH-1:OFF];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
        BVALID     <= 1'b1;
        BRESP      <= wr_ok ? OKAY : SLVERR;
        wr_pulse_o <= wr_sel;
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  // Register storage with per-byte strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= {NUM_REGS{RESET_VAL}};
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < NB; b++)
          if (wr_sel[i] && w_strb[b])
            regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
    end
  end

  // Registered read response, held until RREADY.
  always_ff @(posedge clk) begin
    if (reset) begin
      RVALID <= 1'b0;
      RDATA  <= '0;
      RRESP  <= OKAY;
    end else if (ar_hs) begin
      RVALID <= 1'b1;
      RDATA  <= rd_val;
      RRESP  <= rd_ok ? OKAY : SLVERR;
    end else if (RVALID && RREADY) begin
      RVALID <= 1'b0;
    end
  end
endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register bank. It sits between the AXI-Lite interconnect and a peripheral's control/status logic. It accepts AW and W independently in either order and applies byte-strobed writes. Registers can be marked read-only, in which case reads return live status inputs. Out-of-range and illegal accesses get SLVERR; reads return data with a registered, backpressure-safe response.

Parameters:
AXI_DATA_WIDTH, 32, data bus width; multiple of 8, 32 or 64.
AXI_ADDR_WIDTH, 8, byte address width; must cover NUM_REGS words.
NUM_REGS, 8, number of word registers; 1..2^(AXI_ADDR_WIDTH-log2(AXI_DATA_WIDTH/8)).
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only (reads status_i slice i).
RESET_VAL, 0, AXI_DATA_WIDTH-bit reset value for every RW register.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  AXI_ADDR_WIDTH/3/1/1  write address channel
WDATA/WSTRB/WVALID/WREADY  in/in/in/out  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  write data channel
BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  AXI_ADDR_WIDTH/3/1/1  read address channel
RDATA/RRESP/RVALID/RREADY  out/out/out/in  AXI_DATA_WIDTH/2/1/1  read data channel
regs_o  out  NUM_REGS*AXI_DATA_WIDTH  current RW register contents, reg i at slice i
wr_pulse_o  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written (any strobe)
status_i  in  NUM_REGS*AXI_DATA_WIDTH  live values for RO registers; unused slices ignored

Behaviour:
- Single clock domain, clk. Synchronous active-high reset: every RW reg is set to RESET_VAL. All outputs go to 0, including the READYs, VALIDs, BRESP, RRESP, RDATA and wr_pulse_o. Pending captured AW/W/AR are dropped.
- First cycle after reset deasserts: AWREADY=WREADY=ARREADY=1.
- Decode: index = addr >> log2(AXI_DATA_WIDTH/8). Byte-offset bits are ignored. AWPROT and ARPROT are ignored.
- Write path, one outstanding write:
  - AWREADY=1 while no AW is held and BVALID=0. An AW handshake captures the address and drops AWREADY.
  - WREADY behaves the same for W; the handshake captures data and strobe.
  - AW and W may arrive in the same cycle or in either order, any gap apart.
  - Commit edge: the first edge at which both are held. On it:
    - If index < NUM_REGS and RO_MASK[index]=0: update each byte lane whose WSTRB bit is 1, set BRESP=OKAY(00), set wr_pulse_o[index]=1 for one cycle.
    - Otherwise: no register changes, BRESP=SLVERR(10), no pulse.
  - BVALID=1 from the commit edge. BVALID and BRESP stay stable until BREADY=1. AWREADY/WREADY re-assert on the edge where B completes.
  - Best case: AW+W handshake at edge N, BVALID and new regs_o visible after edge N+1. A write with WSTRB=0 is OKAY, produces a pulse, and changes no data.
- Read path, one outstanding read:
  - ARREADY=1 while RVALID=0.
  - AR handshake at edge N: RDATA/RRESP are registered and RVALID=1 after edge N.
    - In-range RW register: RDATA = reg contents.
    - In-range RO register: RDATA = status_i slice sampled at edge N. RRESP=OKAY.
    - Out of range: RDATA=0, RRESP=SLVERR.
  - RVALID, RDATA and RRESP stay stable until RREADY=1. ARREADY re-asserts on that edge. The read datapath is not combinational.
- Read and write are independent. If a read handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
- Reset asserted mid-transaction aborts everything; the master must not expect a response.

Test Plan:
- After reset, read reg 0..NUM_REGS-1 -> each returns RESET_VAL with RRESP=00. Check regs_o=RESET_VAL; AWREADY/WREADY/ARREADY=1 on the first cycle after reset.
- Write 0xA5A5_1234 to addr 0x04 with AW and W in the same cycle, WSTRB=0xF -> BVALID one cycle later with BRESP=00, wr_pulse_o[1] pulses once, and regs_o slice 1 = 0xA5A5_1234. Then W three cycles before AW, WSTRB=0x2, WDATA=0x0000_FF00 to the same addr -> reg 1 = 0xA5A5_FF34.
- Hold BREADY=0 for 5 cycles after a write -> BVALID and BRESP stay stable; a new AW is not accepted (AWREADY=0) until B completes.
- Write to addr NUM_REGS*4 and to an RO_MASK register -> BRESP=10, no register change, no pulse. Read the same addresses -> the RO register returns status_i with RRESP=00; the out-of-range address returns RDATA=0 with RRESP=10.
- Read with RREADY held 0 while status_i changes -> RDATA stays frozen at the value sampled on the AR handshake.
- Issue a write to reg 2, then assert reset before W arrives -> no BVALID, reg 2 = RESET_VAL. The next full write completes normally.
